// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - MSI line states, bus request codes and controller FSM states
package msi_pkg;

    typedef enum logic [1:0] {
        INVALID  = 2'b00,
        MODIFIED = 2'b01,
        SHARED   = 2'b10
    } line_state_t;

    typedef enum logic [1:0] {
        BUS_INVALIDATE = 2'b00,
        BUS_WRITE_MISS = 2'b01,
        BUS_READ_MISS  = 2'b10
    } bus_type_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        BUS,
        MEMRD,
        FILL
    } fsm_state_t;

endpackage

// File: rtl/msi_snoop_ctrl.sv
// rtl/msi_snoop_ctrl.sv - combinational snoop lookup: next line state and flush decode
// Ports: snoop_valid/snoop_type/snoop_tag describe the peer broadcast; line_state/line_tag
// are the indexed line; hit marks a live tag match, next_state the line's new state,
// flush that this cache must supply the MODIFIED data.
module msi_snoop_ctrl
    import msi_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             snoop_valid,
    input  logic [1:0]       snoop_type,
    input  logic [TAG_W-1:0] snoop_tag,
    input  logic [1:0]       line_state,
    input  logic [TAG_W-1:0] line_tag,
    output logic             hit,
    output logic [1:0]       next_state,
    output logic             flush
);

    always_comb begin
        hit        = snoop_valid && (line_state != INVALID) && (line_tag == snoop_tag);
        next_state = line_state;
        flush      = 1'b0;
        if (hit) begin
            if (line_state == MODIFIED) begin
                if (snoop_type == BUS_READ_MISS) begin
                    next_state = SHARED;
                    flush      = 1'b1;
                end else if (snoop_type == BUS_WRITE_MISS) begin
                    next_state = INVALID;
                    flush      = 1'b1;
                end else if (snoop_type == BUS_INVALIDATE) begin
                    // A peer cannot legally hold a copy of our M line; drop ours without data.
                    next_state = INVALID;
                end
            end else if (snoop_type == BUS_WRITE_MISS || snoop_type == BUS_INVALIDATE) begin
                next_state = INVALID;
            end
        end
    end

endmodule

// File: rtl/msi_snoop_cache_ctrl.sv
// rtl/msi_snoop_cache_ctrl.sv - direct-mapped write-back MSI L1 controller with snoop port
// Ports: cpu_req_*/cpu_resp_* CPU handshake; bus_req_*/bus_grant outgoing broadcast;
// snoop_*/snoop_flush_* peer broadcast and our same-cycle data supply; peer_fill_* data
// flushed by a peer for our miss; mem_req_*/mem_resp_* victim write-back and line reads.
module msi_snoop_cache_ctrl
    import msi_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int INDEX_W = 5,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_write,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              bus_req_valid,
    output logic [1:0]        bus_req_type,
    output logic [ADDR_W-1:0] bus_req_addr,
    input  logic              bus_grant,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_type,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_flush_valid,
    output logic [DATA_W-1:0] snoop_flush_data,
    input  logic              peer_fill_valid,
    input  logic [DATA_W-1:0] peer_fill_data,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0][1:0] line_state;
    logic [TAG_W-1:0]      line_tag  [DEPTH];
    logic [DATA_W-1:0]     line_data [DEPTH];

    fsm_state_t        state, state_nxt;
    bus_type_t         bus_type, bus_type_nxt;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    logic [INDEX_W-1:0] snp_idx;
    logic [TAG_W-1:0]   snp_tag;
    logic               snp_hit, snp_flush;
    logic [1:0]         snp_next;

    assign snp_idx = snoop_addr[INDEX_W-1:0];
    assign snp_tag = snoop_addr[ADDR_W-1:INDEX_W];

    msi_snoop_ctrl #(.TAG_W(TAG_W)) u_snoop (
        .snoop_valid (snoop_valid),
        .snoop_type  (snoop_type),
        .snoop_tag   (snp_tag),
        .line_state  (line_state[snp_idx]),
        .line_tag    (line_tag[snp_idx]),
        .hit         (snp_hit),
        .next_state  (snp_next),
        .flush       (snp_flush)
    );

    assign snoop_flush_valid = snp_flush;
    assign snoop_flush_data  = snp_flush ? line_data[snp_idx] : '0;

    // In IDLE the CPU side looks at the incoming request; afterwards at the latched one.
    logic [ADDR_W-1:0]  cur_addr;
    logic [INDEX_W-1:0] cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic [1:0]         eff_state;
    logic               tag_hit;

    assign cur_addr  = (state == IDLE) ? cpu_req_addr : req_addr;
    assign cur_idx   = cur_addr[INDEX_W-1:0];
    assign cur_tag   = cur_addr[ADDR_W-1:INDEX_W];
    // The CPU FSM sees the line as it will be after this cycle's snoop.
    assign eff_state = (snp_hit && snp_idx == cur_idx) ? snp_next : line_state[cur_idx];
    assign tag_hit   = (eff_state != INVALID) && (line_tag[cur_idx] == cur_tag);

    logic              accept, done, wb_done;
    logic [1:0]        done_state;
    logic [DATA_W-1:0] done_data;

    always_comb begin
        state_nxt    = state;
        bus_type_nxt = bus_type;
        accept       = 1'b0;
        done         = 1'b0;
        wb_done      = 1'b0;
        done_state   = INVALID;
        done_data    = '0;
        case (state)
            IDLE: if (cpu_req_valid) begin
                accept = 1'b1;
                if (tag_hit && !cpu_req_write) begin
                    done       = 1'b1;
                    done_state = eff_state;
                    done_data  = line_data[cur_idx];
                end else if (tag_hit && eff_state == MODIFIED) begin
                    done       = 1'b1;
                    done_state = MODIFIED;
                    done_data  = cpu_req_wdata;
                end else if (tag_hit) begin
                    state_nxt    = BUS;
                    bus_type_nxt = BUS_INVALIDATE;
                end else if (eff_state == MODIFIED) begin
                    state_nxt = WB;
                end else begin
                    state_nxt    = BUS;
                    bus_type_nxt = cpu_req_write ? BUS_WRITE_MISS : BUS_READ_MISS;
                end
            end
            WB: if (mem_req_ready) begin
                wb_done      = 1'b1;
                state_nxt    = BUS;
                bus_type_nxt = req_write ? BUS_WRITE_MISS : BUS_READ_MISS;
            end
            BUS: begin
                if (bus_grant) begin
                    if (bus_type == BUS_INVALIDATE) begin
                        done       = 1'b1;
                        done_state = MODIFIED;
                        done_data  = req_wdata;
                    end else if (peer_fill_valid) begin
                        done       = 1'b1;
                        done_state = req_write ? MODIFIED : SHARED;
                        done_data  = req_write ? req_wdata : peer_fill_data;
                    end else begin
                        state_nxt = MEMRD;
                    end
                end else if (bus_type == BUS_INVALIDATE && eff_state == INVALID) begin
                    // Our S copy was taken away before the upgrade won the bus.
                    bus_type_nxt = BUS_WRITE_MISS;
                end
            end
            MEMRD: begin
                if (peer_fill_valid) begin
                    done       = 1'b1;
                    done_state = req_write ? MODIFIED : SHARED;
                    done_data  = req_write ? req_wdata : peer_fill_data;
                end else if (mem_req_ready) begin
                    state_nxt = FILL;
                end
            end
            FILL: if (peer_fill_valid || mem_resp_valid) begin
                done       = 1'b1;
                done_state = req_write ? MODIFIED : SHARED;
                done_data  = req_write ? req_wdata
                                       : (peer_fill_valid ? peer_fill_data : mem_resp_rdata);
            end
            default: state_nxt = IDLE;
        endcase
        if (done) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus_type   <= BUS_INVALIDATE;
            line_state <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            bus_type   <= bus_type_nxt;
            resp_valid <= done;
            if (done) resp_data <= done_data;
            if (accept) begin
                req_write <= cpu_req_write;
                req_addr  <= cpu_req_addr;
                req_wdata <= cpu_req_wdata;
            end
            // Snoop first; a CPU update to the same line in this cycle overrides it.
            if (snp_hit) line_state[snp_idx] <= snp_next;
            if (wb_done) line_state[cur_idx] <= INVALID;
            if (done)    line_state[cur_idx] <= done_state;
        end
    end

    always_ff @(posedge clk) begin
        if (done) begin
            line_tag[cur_idx]  <= cur_tag;
            line_data[cur_idx] <= done_data;
        end
    end

    assign cpu_req_ready  = (state == IDLE);
    assign cpu_resp_valid = resp_valid;
    assign cpu_resp_rdata = resp_data;

    assign bus_req_valid = (state == BUS);
    assign bus_req_type  = bus_req_valid ? bus_type : 2'b00;
    assign bus_req_addr  = bus_req_valid ? req_addr : '0;

    assign mem_req_valid = (state == WB) || (state == MEMRD);
    assign mem_req_write = (state == WB);
    assign mem_req_addr  = (state == WB)    ? {line_tag[cur_idx], cur_idx} :
                           (state == MEMRD) ? req_addr : '0;
    assign mem_req_wdata = (state == WB) ? line_data[cur_idx] : '0;

endmodule

// File: tb/tb_msi_snoop_cache_ctrl.sv
// tb/tb_msi_snoop_cache_ctrl.sv - randomized bench for msi_snoop_cache_ctrl against a line-level model
module tb_msi_snoop_cache_ctrl;

    localparam int ST_I = 0, ST_M = 1, ST_S = 2;
    localparam int B_INV = 0, B_WM = 1, B_RM = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid, cpu_req_write;
    logic [8:0]  cpu_req_addr;
    logic [15:0] cpu_req_wdata;
    logic        cpu_req_ready, cpu_resp_valid;
    logic [15:0] cpu_resp_rdata;
    logic        bus_req_valid;
    logic [1:0]  bus_req_type;
    logic [8:0]  bus_req_addr;
    logic        bus_grant;
    logic        snoop_valid;
    logic [1:0]  snoop_type;
    logic [8:0]  snoop_addr;
    logic        snoop_flush_valid;
    logic [15:0] snoop_flush_data;
    logic        peer_fill_valid;
    logic [15:0] peer_fill_data;
    logic        mem_req_valid, mem_req_write;
    logic [8:0]  mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_req_ready, mem_resp_valid;
    logic [15:0] mem_resp_rdata;

    always #5 clk = ~clk;

    msi_snoop_cache_ctrl #(.ADDR_W(9), .INDEX_W(5), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_type(bus_req_type),
        .bus_req_addr(bus_req_addr), .bus_grant(bus_grant),
        .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr),
        .snoop_flush_valid(snoop_flush_valid), .snoop_flush_data(snoop_flush_data),
        .peer_fill_valid(peer_fill_valid), .peer_fill_data(peer_fill_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;
    int mst   [32];
    int mtag  [32];
    int mdata [32];
    int wb_delay = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_addr();
        return int'(($urandom_range(0, 3) << 5) | $urandom_range(0, 3));
    endfunction

    task automatic clear_inputs();
        cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        bus_grant = 0; snoop_valid = 0; snoop_type = '0; snoop_addr = '0;
        peer_fill_valid = 0; peer_fill_data = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    endtask

    task automatic reset_dut(input string tag);
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 32; i++) mst[i] = ST_I;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(cpu_req_ready), 1);
        chk({tag, "_resp_valid"}, 32'(cpu_resp_valid), 0);
        chk({tag, "_resp_rdata"}, 32'(cpu_resp_rdata), 0);
        chk({tag, "_bus_valid"}, 32'(bus_req_valid), 0);
        chk({tag, "_bus_type"}, 32'(bus_req_type), 0);
        chk({tag, "_bus_addr"}, 32'(bus_req_addr), 0);
        chk({tag, "_flush_valid"}, 32'(snoop_flush_valid), 0);
        chk({tag, "_flush_data"}, 32'(snoop_flush_data), 0);
        chk({tag, "_mem_valid"}, 32'(mem_req_valid), 0);
        chk({tag, "_mem_write"}, 32'(mem_req_write), 0);
        chk({tag, "_mem_addr"}, 32'(mem_req_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_req_wdata), 0);
        tick();
    endtask

    // Peer broadcast seen by this cache; model decides flush and new line state.
    task automatic do_snoop(input int typ, input int addr);
        int idx, tg, fd;
        bit fl;
        idx = addr & 31; tg = addr >> 5; fl = 0; fd = 0;
        if (mst[idx] != ST_I && mtag[idx] == tg) begin
            if (mst[idx] == ST_M) begin
                if (typ == B_RM)      begin fl = 1; fd = mdata[idx]; mst[idx] = ST_S; end
                else if (typ == B_WM) begin fl = 1; fd = mdata[idx]; mst[idx] = ST_I; end
                else                  mst[idx] = ST_I;
            end else if (typ != B_RM) begin
                mst[idx] = ST_I;
            end
        end
        snoop_valid = 1; snoop_type = 2'(typ); snoop_addr = 9'(addr);
        @(negedge clk);
        chk("snoop_flush_valid", 32'(snoop_flush_valid), 32'(fl));
        if (fl) chk("snoop_flush_data", 32'(snoop_flush_data), fd);
        tick();
        snoop_valid = 0;
    endtask

    // mode: 0 peer data on grant, 1 peer+mem in MEMRD then a late mem_resp,
    //       2 memory fill, 3 peer+mem together in FILL.
    task automatic cpu_op(input bit wr, input int addr, input int wd, input int mode,
                          input bit snp_bus, input int mem_d, input int peer_d);
        int idx, tg, typ, d, fill;
        bit hit, wb, late;
        idx = addr & 31; tg = addr >> 5;
        hit = (mst[idx] != ST_I) && (mtag[idx] == tg);
        wb = !hit && (mst[idx] == ST_M);
        fill = 0; late = 0;
        cpu_req_valid = 1; cpu_req_write = wr; cpu_req_addr = 9'(addr); cpu_req_wdata = 16'(wd);
        @(negedge clk);
        chk("cpu_req_ready", 32'(cpu_req_ready), 1);
        tick();
        cpu_req_valid = 0;
        if (hit && (!wr || mst[idx] == ST_M)) begin
            @(negedge clk);
            chk("hit_resp_valid", 32'(cpu_resp_valid), 1);
            chk("hit_bus_idle", 32'(bus_req_valid), 0);
            if (!wr) chk("hit_rdata", 32'(cpu_resp_rdata), mdata[idx]);
            else mdata[idx] = wd;
            tick();
            return;
        end
        if (wb) begin
            d = (wb_delay >= 0) ? wb_delay : int'($urandom_range(0, 3));
            for (int c = 0; c <= d; c++) begin
                mem_req_ready = (c == d);
                @(negedge clk);
                chk("wb_valid", 32'(mem_req_valid), 1);
                chk("wb_write", 32'(mem_req_write), 1);
                chk("wb_addr", 32'(mem_req_addr), (mtag[idx] << 5) | idx);
                chk("wb_data", 32'(mem_req_wdata), mdata[idx]);
                chk("wb_no_bus", 32'(bus_req_valid), 0);
                tick();
            end
            mem_req_ready = 0;
            mst[idx] = ST_I;
        end
        typ = hit ? B_INV : (wr ? B_WM : B_RM);
        d = int'($urandom_range(0, 2)) + (snp_bus ? 1 : 0);
        for (int c = 0; c <= d; c++) begin
            bus_grant = (c == d);
            if (snp_bus && c == 0) begin
                snoop_valid = 1; snoop_type = 2'(B_WM); snoop_addr = 9'(addr);
            end
            peer_fill_valid = (c == d) && (mode == 0) && (typ != B_INV);
            peer_fill_data = 16'(peer_d);
            @(negedge clk);
            chk("bus_valid", 32'(bus_req_valid), 1);
            chk("bus_type", 32'(bus_req_type), typ);
            chk("bus_addr", 32'(bus_req_addr), addr);
            chk("bus_no_resp", 32'(cpu_resp_valid), 0);
            if (snp_bus && c == 0) chk("bus_snoop_noflush", 32'(snoop_flush_valid), 0);
            tick();
            if (snp_bus && c == 0) begin
                snoop_valid = 0;
                if (mst[idx] != ST_I && mtag[idx] == tg) mst[idx] = ST_I;
                if (typ == B_INV) typ = B_WM;
            end
        end
        bus_grant = 0; peer_fill_valid = 0;
        if (typ == B_INV) begin
            fill = 0;
        end else if (mode == 0) begin
            fill = peer_d;
        end else begin
            d = int'($urandom_range(0, 2));
            for (int c = 0; c <= d; c++) begin
                if (mode == 1 && c == d) begin
                    peer_fill_valid = 1; peer_fill_data = 16'(peer_d);
                    mem_resp_valid = 1; mem_resp_rdata = 16'(mem_d);
                    mem_req_ready = 0;
                end else begin
                    mem_req_ready = (c == d);
                end
                @(negedge clk);
                chk("memrd_valid", 32'(mem_req_valid), 1);
                chk("memrd_write", 32'(mem_req_write), 0);
                chk("memrd_addr", 32'(mem_req_addr), addr);
                tick();
            end
            mem_req_ready = 0; peer_fill_valid = 0; mem_resp_valid = 0;
            if (mode == 1) begin
                fill = peer_d; late = 1;
            end else begin
                d = int'($urandom_range(0, 2));
                for (int c = 0; c <= d; c++) begin
                    mem_resp_valid = (c == d); mem_resp_rdata = 16'(mem_d);
                    peer_fill_valid = (c == d) && (mode == 3); peer_fill_data = 16'(peer_d);
                    @(negedge clk);
                    chk("fill_mem_idle", 32'(mem_req_valid), 0);
                    chk("fill_no_resp", 32'(cpu_resp_valid), 0);
                    tick();
                end
                mem_resp_valid = 0; peer_fill_valid = 0;
                fill = (mode == 3) ? peer_d : mem_d;
            end
        end
        mtag[idx] = tg;
        if (wr) begin mst[idx] = ST_M; mdata[idx] = wd; end
        else    begin mst[idx] = ST_S; mdata[idx] = fill; end
        @(negedge clk);
        chk("done_resp_valid", 32'(cpu_resp_valid), 1);
        if (!wr) chk("done_rdata", 32'(cpu_resp_rdata), fill);
        tick();
        if (late) begin
            mem_resp_valid = 1; mem_resp_rdata = 16'(mem_d);
            @(negedge clk);
            chk("late_no_resp0", 32'(cpu_resp_valid), 0);
            tick();
            mem_resp_valid = 0;
            @(negedge clk);
            chk("late_no_resp1", 32'(cpu_resp_valid), 0);
            tick();
        end
    endtask

    initial begin
        int a;
        for (int i = 0; i < 32; i++) begin mst[i] = ST_I; mtag[i] = 0; mdata[i] = 0; end
        reset_dut("rst");

        // 1: read miss filled from memory, then a 1-cycle hit
        cpu_op(0, 'h025, 0, 2, 0, 'h1234, 'h0);
        cpu_op(0, 'h025, 0, 2, 0, 'h0, 'h0);
        // 2: upgrade S->M via INVALIDATE, then a peer read pulls the data
        cpu_op(1, 'h025, 'hBEEF, 2, 0, 'h0, 'h0);
        do_snoop(B_RM, 'h025);
        // 3: dirty victim written back with a slow memory
        cpu_op(1, 'h025, 'hBEEF, 2, 0, 'h0, 'h0);
        wb_delay = 3;
        cpu_op(0, 'h045, 0, 2, 0, 'h5555, 'h0);
        wb_delay = -1;
        cpu_op(0, 'h045, 0, 2, 0, 'h0, 'h0);
        // 4: pending INVALIDATE loses its copy and becomes WRITE_MISS
        cpu_op(0, 'h025, 0, 2, 0, 'h1111, 'h0);
        cpu_op(1, 'h025, 'hCAFE, 2, 1, 'h2222, 'h0);
        do_snoop(B_RM, 'h025);
        // 5: peer data beats memory in MEMRD; late memory data is dropped
        cpu_op(0, 'h0C7, 0, 1, 0, 'h3333, 'h7777);
        cpu_op(0, 'h0C7, 0, 2, 0, 'h0, 'h0);

        // 6: reset while waiting in FILL
        cpu_req_valid = 1; cpu_req_write = 0; cpu_req_addr = 9'h0A3;
        tick();
        cpu_req_valid = 0; bus_grant = 1;
        tick();
        bus_grant = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        @(negedge clk);
        chk("t6_in_fill_not_ready", 32'(cpu_req_ready), 0);
        tick();
        reset_dut("t6");
        @(negedge clk);
        chk("t6_no_resp", 32'(cpu_resp_valid), 0);
        tick();
        for (int i = 0; i < 32; i++) begin
            a = int'(($urandom_range(0, 15) << 5) | i);
            cpu_req_valid = 1; cpu_req_write = 0; cpu_req_addr = 9'(a);
            tick();
            cpu_req_valid = 0;
            @(negedge clk);
            chk("t6_miss_no_resp", 32'(cpu_resp_valid), 0);
            chk("t6_miss_bus", 32'(bus_req_valid), 1);
            rst = 1;
            tick();
            rst = 0;
        end
        reset_dut("t6b");

        // Random traffic with interleaved peer snoops
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 1) == 1) do_snoop(int'($urandom_range(0, 2)), rand_addr());
            cpu_op(1'($urandom_range(0, 1)), rand_addr(), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 3)), 1'b0,
                   int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
